// File: rtl/keypad_pkg.sv
// Shared types and elaboration helpers for the parametrised keypad matrix scanner.
// Widths depend on instance parameters, so they are exposed as constant functions.
package keypad_pkg;

  localparam int KW_MAX = 8;

  typedef struct packed {
    logic [KW_MAX-1:0] code;
    logic              is_release;
  } evt_t;

  function automatic int key_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

  function automatic int kw_of(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int dbw_of(input int debounce);
    return $clog2(debounce + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The commit of ROWS rows must finish before the next sample is taken.
  function automatic bit scan_div_ok(input int scan_div, input int rows);
    return (scan_div >= 4) && (scan_div >= rows + 1);
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Event FIFO with valid/ready head, drop-on-full and a sticky overflow flag.
// The head is read straight from storage flops, so it holds while valid && !ready.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic aclk,
  input  logic areset,
  input  logic push,
  input  evt_t push_evt,
  input  logic ready,
  output logic valid,
  output evt_t head,
  output logic overflow
);

  localparam int PW = $clog2(DEPTH);

  evt_t          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          pop;
  logic          accept;

  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];
  assign pop    = valid && ready;
  assign accept = push && ((count < (PW+1)'(DEPTH)) || pop);

  // NOTE: storage is deliberately not reset; count gates valid, so stale entries are never seen.
  always_ff @(posedge aclk) begin
    if (accept) mem[wr_ptr] <= push_evt;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// ROWS x COLS active-low keypad scanner: one-cold column drive, per-key debounce,
// and press/release events queued through keypad_evt_fifo.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 8,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  output logic [COLS-1:0]               o_col_n,
  input  logic [ROWS-1:0]               i_row_n,
  output logic [ROWS*COLS-1:0]          o_key_state,
  output logic [ROWS*COLS-1:0]          o_key_push,
  output logic                          o_evt_valid,
  output logic [kw_of(ROWS, COLS)-1:0]  o_evt_code,
  output logic                          o_evt_release,
  input  logic                          i_evt_ready,
  output logic                          o_overflow
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = kw_of(ROWS, COLS);
  localparam int DBW = dbw_of(DEBOUNCE);
  localparam int CW  = idx_w(SCAN_DIV);
  localparam int CLW = idx_w(COLS);
  localparam int RW  = idx_w(ROWS);

  if (!scan_div_ok(SCAN_DIV, ROWS)) begin : g_bad_scan_div
    $error("keypad_matrix_scanner: SCAN_DIV must be >= max(4, ROWS+1)");
  end
  if (KW > KW_MAX) begin : g_bad_key_count
    $error("keypad_matrix_scanner: ROWS*COLS exceeds the event code width");
  end

  logic           running;
  logic [CLW-1:0] col, col_nxt;
  logic [CW-1:0]  cyc, cyc_nxt;
  logic [ROWS-1:0] sync1, sync2;
  logic [ROWS-1:0] samp;
  logic [CLW-1:0] s_col;
  logic           s_valid;
  logic [DBW-1:0] cnt [NK];

  logic [RW-1:0]  c_row;
  logic [KW-1:0]  c_key;
  logic           c_en, c_bit, c_diff, c_flip;
  evt_t           push_evt;
  evt_t           head;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    col_nxt = col;
    cyc_nxt = cyc;
    if (running) begin
      if (cyc == CW'(SCAN_DIV - 1)) begin
        cyc_nxt = '0;
        col_nxt = (col == CLW'(COLS - 1)) ? '0 : col + 1'b1;
      end else begin
        cyc_nxt = cyc + 1'b1;
      end
    end
  end

  // running holds the scan idle for the cycle in which reset is released.
  always_ff @(posedge aclk) begin
    if (areset) begin
      running <= 1'b0;
      col     <= '0;
      cyc     <= '0;
      o_col_n <= '1;
      sync1   <= '1;
      sync2   <= '1;
      samp    <= '0;
      s_col   <= '0;
      s_valid <= 1'b0;
    end else begin
      running <= 1'b1;
      col     <= col_nxt;
      cyc     <= cyc_nxt;
      o_col_n <= ~(COLS'(1) << col_nxt);
      sync1   <= i_row_n;
      sync2   <= sync1;
      if (running && (cyc == CW'(SCAN_DIV - 1))) begin
        samp    <= ~sync2;
        s_col   <= col;
        s_valid <= 1'b1;
      end
    end
  end

  // One row of the previous column's sample is committed per cycle.
  always_comb begin
    c_row    = RW'(cyc);
    c_key    = KW'(key_idx(int'(c_row), int'(s_col), COLS));
    c_en     = s_valid && (cyc < CW'(ROWS));
    c_bit    = samp[c_row];
    c_diff   = (c_bit != o_key_state[c_key]);
    c_flip   = c_en && c_diff && (cnt[c_key] == DBW'(DEBOUNCE - 1));
    push_evt = '{code: KW_MAX'(c_key), is_release: !c_bit};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      o_key_state <= '0;
      o_key_push  <= '0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      o_key_push <= '0;
      if (c_en) begin
        if (!c_diff) begin
          cnt[c_key] <= '0;
        end else if (c_flip) begin
          o_key_state[c_key] <= c_bit;
          o_key_push[c_key]  <= c_bit;
          cnt[c_key]         <= '0;
        end else begin
          cnt[c_key] <= cnt[c_key] + 1'b1;
        end
      end
    end
  end

  keypad_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .areset   (areset),
    .push     (c_flip),
    .push_evt (push_evt),
    .ready    (i_evt_ready),
    .valid    (o_evt_valid),
    .head     (head),
    .overflow (o_overflow)
  );

  assign o_evt_code    = KW'(head.code);
  assign o_evt_release = head.is_release;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scenario bench for keypad_matrix_scanner with a scoreboard of expected FIFO events.
module tb_keypad_matrix_scanner;

  localparam int ROWS = 4, COLS = 3, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int NK = ROWS * COLS;
  localparam int KW = 4;

  logic            aclk;
  logic            areset;
  logic [COLS-1:0] o_col_n;
  logic [ROWS-1:0] i_row_n;
  logic [NK-1:0]   o_key_state;
  logic [NK-1:0]   o_key_push;
  logic            o_evt_valid;
  logic [KW-1:0]   o_evt_code;
  logic            o_evt_release;
  logic            i_evt_ready;
  logic            o_overflow;

  typedef struct {
    int code;
    bit rel;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc_t    = 0;
  logic [NK-1:0] pressed  = '0;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .o_col_n       (o_col_n),
    .i_row_n       (i_row_n),
    .o_key_state   (o_key_state),
    .o_key_push    (o_key_push),
    .o_evt_valid   (o_evt_valid),
    .o_evt_code    (o_evt_code),
    .o_evt_release (o_evt_release),
    .i_evt_ready   (i_evt_ready),
    .o_overflow    (o_overflow)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Physical key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    i_row_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS + c] && !o_col_n[c]) i_row_n[r] = 1'b0;
  end

  // Cycle 0 is the first cycle after the edge that sees reset low.
  initial begin
    forever begin
      @(posedge aclk);
      if (areset) cyc_t = -1;
      else        cyc_t = cyc_t + 1;
    end
  end

  // Scoreboard: every handshake must match the oldest expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && o_evt_valid && i_evt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL evt_unexpected t=%0d got code=%0d rel=%0d want none", cyc_t, o_evt_code, o_evt_release);
        end else begin
          e = exp_q.pop_front();
          if ({o_evt_code, o_evt_release} !== {KW'(e.code), e.rel}) begin
            failures++;
            $display("FAIL evt_order t=%0d got code=%0d rel=%0d want code=%0d rel=%0d",
                     cyc_t, o_evt_code, o_evt_release, e.code, e.rel);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d got no finish want finish", cyc_t);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_evt(input int code, input bit rel);
    exp_q.push_back('{code: code, rel: rel});
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    exp_q.delete();
    repeat (3) step();
    areset = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d want pending=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    pressed     = 12'h021;
    i_evt_ready = 1'b1;
    areset      = 1'b1;
    repeat (3) step();
    checks++;
    if (o_col_n !== 3'b111) begin failures++; $display("FAIL reset_col got=%b want=111", o_col_n); end
    checks++;
    if (o_key_state !== '0) begin failures++; $display("FAIL reset_state got=%h want=0", o_key_state); end
    checks++;
    if (o_key_push !== '0) begin failures++; $display("FAIL reset_push got=%h want=0", o_key_push); end
    checks++;
    if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_evt_valid); end
    checks++;
    if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", o_overflow); end
    pressed = '0;
  endtask

  task automatic test_scan();
    logic [COLS-1:0] want;
    apply_reset();
    for (int i = 0; i < 2 * COLS * SCAN_DIV; i++) begin
      want = ~(COLS'(1) << ((cyc_t / SCAN_DIV) % COLS));
      checks++;
      if (o_col_n !== want) begin
        failures++;
        $display("FAIL scan_col t=%0d got=%b want=%b", cyc_t, o_col_n, want);
      end
      checks++;
      if (o_key_state !== '0 || o_evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL scan_idle t=%0d got state=%h valid=%b want state=0 valid=0", cyc_t, o_key_state, o_evt_valid);
      end
      step();
    end
  endtask

  task automatic test_press_release();
    int pulses = 0;
    apply_reset();
    i_evt_ready = 1'b1;
    pressed     = 12'h020;
    expect_evt(5, 1'b0);
    while (cyc_t < 150) begin
      if (o_key_push[5]) pulses++;
      if (cyc_t == 73) begin
        checks++;
        if (o_key_state !== '0) begin failures++; $display("FAIL press_early got=%h want=0", o_key_state); end
      end
      if (cyc_t == 74) begin
        checks++;
        if (o_key_push !== 12'h020) begin failures++; $display("FAIL press_pulse got=%h want=020", o_key_push); end
        checks++;
        if (o_key_state !== 12'h020) begin failures++; $display("FAIL press_state got=%h want=020", o_key_state); end
        pressed = '0;
        expect_evt(5, 1'b1);
      end
      if (cyc_t == 75) begin
        checks++;
        if (o_key_push !== '0) begin failures++; $display("FAIL press_pulse_end got=%h want=0", o_key_push); end
      end
      if (cyc_t == 145) begin
        checks++;
        if (o_key_state !== 12'h020) begin failures++; $display("FAIL release_early got=%h want=020", o_key_state); end
      end
      if (cyc_t == 146) begin
        checks++;
        if (o_key_state !== '0) begin failures++; $display("FAIL release_state got=%h want=0", o_key_state); end
      end
      step();
    end
    checks++;
    if (pulses != 1) begin failures++; $display("FAIL press_pulse_count got=%0d want=1", pulses); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL press_events got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    bit pattern [9] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
    apply_reset();
    i_evt_ready = 1'b1;
    for (int f = 0; f < 9; f++) begin
      pressed = pattern[f] ? 12'h020 : 12'h000;
      for (int i = 0; i < COLS * SCAN_DIV; i++) begin
        if (o_key_push !== '0) begin
          checks++;
          failures++;
          $display("FAIL bounce_pulse t=%0d got=%h want=0", cyc_t, o_key_push);
        end
        step();
      end
      checks++;
      if (o_key_state !== '0) begin
        failures++;
        $display("FAIL bounce_state frame=%0d got=%h want=0", f, o_key_state);
      end
    end
    checks++;
    if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL bounce_valid got=%b want=0", o_evt_valid); end
  endtask

  task automatic test_two_keys();
    apply_reset();
    i_evt_ready = 1'b1;
    pressed     = 12'h402;
    expect_evt(1, 1'b0);
    expect_evt(10, 1'b0);
    while (cyc_t < 72) begin
      if (cyc_t == 65) begin
        checks++;
        if (o_key_push !== 12'h002) begin failures++; $display("FAIL two_first got=%h want=002", o_key_push); end
      end
      if (cyc_t == 66) begin
        checks++;
        if (o_key_push !== '0) begin failures++; $display("FAIL two_gap got=%h want=0", o_key_push); end
      end
      if (cyc_t == 68) begin
        checks++;
        if (o_key_push !== 12'h400) begin failures++; $display("FAIL two_second got=%h want=400", o_key_push); end
      end
      step();
    end
    checks++;
    if (o_key_state !== 12'h402) begin failures++; $display("FAIL two_state got=%h want=402", o_key_state); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL two_events got pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    apply_reset();
    i_evt_ready = 1'b0;
    pressed     = 12'h24B;
    expect_evt(0, 1'b0);
    expect_evt(3, 1'b0);
    expect_evt(6, 1'b0);
    expect_evt(9, 1'b0);
    while (cyc_t < 70) begin
      if (cyc_t == 61) begin
        checks++;
        if (o_evt_valid !== 1'b1 || o_evt_code !== 4'd0) begin
          failures++;
          $display("FAIL ovf_head got valid=%b code=%0d want valid=1 code=0", o_evt_valid, o_evt_code);
        end
      end
      if (cyc_t == 64) begin
        checks++;
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b want=0", o_overflow); end
      end
      if (cyc_t == 65) begin
        checks++;
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", o_overflow); end
      end
      step();
    end
    checks++;
    if (o_key_state !== 12'h24B) begin failures++; $display("FAIL ovf_state got=%h want=24b", o_key_state); end
    checks++;
    if (o_evt_code !== 4'd0 || o_evt_release !== 1'b0) begin
      failures++;
      $display("FAIL ovf_head_hold got code=%0d rel=%b want code=0 rel=0", o_evt_code, o_evt_release);
    end
    i_evt_ready = 1'b1;
    wait_drain("ovf");
    checks++;
    if (o_evt_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got valid=%b want 0", o_evt_valid); end
    checks++;
    if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", o_overflow); end
  endtask

  task automatic test_reset_mid_commit();
    apply_reset();
    i_evt_ready = 1'b0;
    pressed     = 12'h64B;
    while (cyc_t < 66) begin
      if (cyc_t == 65) begin
        checks++;
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL mid_ovf_before got=%b want=1", o_overflow); end
      end
      step();
    end
    areset = 1'b1;
    step();
    checks++;
    if (o_col_n !== 3'b111 || o_key_state !== '0 || o_key_push !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got col=%b state=%h push=%h want col=111 state=0 push=0",
               o_col_n, o_key_state, o_key_push);
    end
    checks++;
    if (o_evt_valid !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_fifo got valid=%b ovf=%b want valid=0 ovf=0", o_evt_valid, o_overflow);
    end
    exp_q.delete();
    i_evt_ready = 1'b1;
    expect_evt(0, 1'b0);
    expect_evt(3, 1'b0);
    expect_evt(6, 1'b0);
    expect_evt(9, 1'b0);
    expect_evt(1, 1'b0);
    expect_evt(10, 1'b0);
    areset = 1'b0;
    step();
    while (cyc_t < 70) begin
      if (cyc_t == 56) begin
        checks++;
        if (o_key_state !== '0) begin failures++; $display("FAIL mid_recommit_early got=%h want=0", o_key_state); end
      end
      if (cyc_t == 68) begin
        checks++;
        if (o_key_state !== 12'h64B) begin failures++; $display("FAIL mid_recommit got=%h want=64b", o_key_state); end
      end
      step();
    end
    wait_drain("mid");
    checks++;
    if (o_overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf_after got=%b want=0", o_overflow); end
  endtask

  initial begin
    areset      = 1'b1;
    i_evt_ready = 1'b0;
    test_reset();
    test_scan();
    test_press_release();
    test_bounce();
    test_two_keys();
    test_overflow();
    test_reset_mid_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
